moore_counter_n: RTL and testbench
==================================

MOORE_COUNTER_N -- requirements
Module: moore_counter_n

Interface
REQ-001 Parameter WIDTH, default 4: state register width in bits, legal range 2..16.
REQ-002 Parameter MODULO, default 16: count modulus, legal range 2..2^WIDTH.
REQ-003 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 Port rst, input, 1: one clock; reset is synchronous and active-high.
REQ-005 Port x_in, input, 1: count request (level, or rising edge when MOORE_EDGE_EN is defined).
REQ-006 Port en, input, 1: count enable; when 0 the counter holds.
REQ-007 Port dir, input, 1: 0 = count up, 1 = count down.
REQ-008 Port load, input, 1: synchronous load request.
REQ-009 Port load_val, input, WIDTH: value for load.
REQ-010 Port state, output, WIDTH: current registered state.
REQ-011 Port next_state, output, WIDTH: combinational next state, equal to the value state takes at the next posedge clk.
REQ-012 Port tc, output, 1: terminal count, high iff state == MODULO-1; a pure function of state (Moore).
REQ-013 Port wrap, output, 1: registered one-cycle pulse marking a wrap.

Function
REQ-014 Update priority per posedge clk: rst > load > count > hold.
REQ-015 Count event "cnt": (en && x_in), or (en && x_in && !x_q) when MOORE_EDGE_EN is defined.
REQ-016 Up (dir=0) on cnt: state == MODULO-1 -> 0, else state+1.
REQ-017 Down (dir=1) on cnt: state == 0 -> MODULO-1, else state-1.
REQ-018 No cnt and no load: state holds and next_state equals state.
REQ-019 Load: state <= load_val if load_val < MODULO, else MODULO-1 (clamp); load ignores en, x_in and dir.
REQ-020 wrap goes high for exactly one cycle, in the cycle after any count-driven transition MODULO-1 -> 0 (up) or 0 -> MODULO-1 (down).
REQ-021 A load never asserts wrap, even when the loaded value equals the wrap target.
REQ-022 Direction change takes effect on the next cnt with no extra latency; dir toggling without cnt leaves state unchanged.
REQ-023 next_state is computed with the same priority as REQ-014, so next_state = 0 whenever rst is high.
REQ-024 Arithmetic is modulo MODULO, never modulo 2^WIDTH; state never holds a value >= MODULO.

Reset
REQ-025 With rst high at posedge clk: state <= 0, wrap <= 0, x_q <= 0; tc follows state (0 unless MODULO == 1, which is illegal).
REQ-026 Reset mid-count overrides a simultaneous load or cnt, and a wrap pending for the next cycle is cancelled.

Configuration
REQ-027 Macro MOORE_EDGE_EN defined: a register x_q samples x_in every cycle, and only a 0 -> 1 transition of x_in counts, so a held-high x_in yields one count.
REQ-028 MOORE_EDGE_EN undefined: no x_q register; each cycle with en && x_in high counts (level mode), matching the legacy 2-bit counter behaviour.

Verification (WIDTH=4, MODULO=10)
REQ-029 Reset, then dir=0, en=1, x_in=1 for 10 cycles -> state 0,1,..,9,0; tc high while state=9; wrap high one cycle after the 9 -> 0 transition.
REQ-030 From state=0: dir=1, one cnt -> state=9, tc=1, wrap pulses once; a further cnt -> state=8, tc=0.
REQ-031 load=1, load_val=12, with x_in=1 in the same cycle -> state=9 (clamped), wrap stays 0; load_val=5 -> state=5.
REQ-032 state=7, rst=1 together with load=1 and x_in=1 -> state=0 next cycle, next_state=0 during the rst cycle, wrap=0.
REQ-033 MOORE_EDGE_EN defined: x_in held high for 5 cycles, en=1 -> state advances by exactly 1; without the macro -> state advances by 5.
REQ-034 en=0 with x_in toggling for 8 cycles -> state unchanged, wrap stays 0; throughout every test, next_state equals the next sampled state.

Source files
------------

// File: rtl/moore_counter_n.sv
// rtl/moore_counter_n.sv - modulo-N up/down Moore counter with load, terminal count and wrap pulse
// Optional edge-triggered counting when MOORE_EDGE_EN is defined.
module moore_counter_n #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_in,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state,
    output logic             tc,
    output logic             wrap
);

    // MODULO may equal 2^WIDTH, so the modulus itself needs one extra bit.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULO);
    localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] ZERO  = '0;
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic cnt;
    logic wrap_next;

`ifdef MOORE_EDGE_EN
    logic x_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= 1'b0;
        end else begin
            x_q <= x_in;
        end
    end

    assign cnt = en && x_in && !x_q;
`else
    assign cnt = en && x_in;
`endif

    always_comb begin
        next_state = state;
        wrap_next  = 1'b0;
        if (rst) begin
            next_state = ZERO;
        end else if (load) begin
            next_state = ({1'b0, load_val} < MOD_W) ? load_val : TOP;
        end else if (cnt) begin
            if (!dir) begin
                if (state == TOP) begin
                    next_state = ZERO;
                    wrap_next  = 1'b1;
                end else begin
                    next_state = state + ONE;
                end
            end else begin
                if (state == ZERO) begin
                    next_state = TOP;
                    wrap_next  = 1'b1;
                end else begin
                    next_state = state - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ZERO;
            wrap  <= 1'b0;
        end else begin
            state <= next_state;
            wrap  <= wrap_next;
        end
    end

    assign tc = (state == TOP);

endmodule

// File: tb/tb_moore_counter_n.sv
// tb/tb_moore_counter_n.sv - directed table-driven bench for moore_counter_n (WIDTH=4, MODULO=10)
module tb_moore_counter_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x_in = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] state;
    logic [3:0] next_state;
    logic       tc;
    logic       wrap;

    int n_cmp = 0;
    int n_bad = 0;

    moore_counter_n #(.WIDTH(4), .MODULO(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .x_in       (x_in),
        .en         (en),
        .dir        (dir),
        .load       (load),
        .load_val   (load_val),
        .state      (state),
        .next_state (next_state),
        .tc         (tc),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       load;
        logic [3:0] lv;
        logic       en;
        logic       x;
        logic       dir;
        logic [3:0] exp_state;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic ld, logic [3:0] lv, logic e, logic x,
                                logic d, logic [3:0] es, logic ew);
        vec_t v;
        v.rst = r; v.load = ld; v.lv = lv; v.en = e; v.x = x; v.dir = d;
        v.exp_state = es; v.exp_wrap = ew;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check next_state before the edge and outputs after it.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst = v.rst; load = v.load; load_val = v.lv; en = v.en; x_in = v.x; dir = v.dir;
        #1;
        chk({tag, ".next_state"}, int'(next_state), int'(v.exp_state));
        @(posedge clk);
        #1;
        chk({tag, ".state"}, int'(state), int'(v.exp_state));
        chk({tag, ".tc"}, int'(tc), (v.exp_state == 4'd9) ? 1 : 0);
        chk({tag, ".wrap"}, int'(wrap), int'(v.exp_wrap));
    endtask

    initial begin
        int edge_adv;
        //                 rst ld lv    en x  dir state wrap
        vecs.push_back(mk(1, 0, 4'd0, 0, 0, 0, 4'd0, 0));
        for (int i = 1; i <= 9; i++)
            vecs.push_back(mk(0, 0, 4'd0, 1, 1, 0, 4'(i), 0));
        vecs.push_back(mk(0, 0, 4'd0,  1, 1, 0, 4'd0, 1));   // 9 -> 0 wrap
        vecs.push_back(mk(0, 0, 4'd0,  1, 1, 0, 4'd1, 0));
        vecs.push_back(mk(0, 1, 4'd9,  0, 0, 0, 4'd9, 0));
        vecs.push_back(mk(0, 1, 4'd0,  1, 1, 0, 4'd0, 0));   // load onto wrap target, no wrap
        vecs.push_back(mk(0, 0, 4'd0,  1, 1, 1, 4'd9, 1));   // down 0 -> 9
        vecs.push_back(mk(0, 0, 4'd0,  1, 1, 1, 4'd8, 0));
        vecs.push_back(mk(0, 1, 4'd12, 1, 1, 0, 4'd9, 0));   // clamp
        vecs.push_back(mk(0, 1, 4'd5,  1, 1, 1, 4'd5, 0));
        vecs.push_back(mk(0, 1, 4'd15, 0, 0, 0, 4'd9, 0));
        vecs.push_back(mk(0, 0, 4'd0,  0, 1, 0, 4'd9, 0));   // en low holds
        vecs.push_back(mk(0, 0, 4'd0,  1, 0, 1, 4'd9, 0));   // dir toggles, no cnt
        vecs.push_back(mk(0, 0, 4'd0,  1, 1, 0, 4'd0, 1));
        vecs.push_back(mk(0, 0, 4'd0,  1, 1, 1, 4'd9, 1));   // immediate reversal
        vecs.push_back(mk(0, 0, 4'd0,  1, 0, 0, 4'd9, 0));
        vecs.push_back(mk(0, 1, 4'd7,  0, 0, 0, 4'd7, 0));
        vecs.push_back(mk(1, 1, 4'd3,  1, 1, 0, 4'd0, 0));   // rst beats load and cnt
        vecs.push_back(mk(0, 1, 4'd9,  0, 0, 0, 4'd9, 0));
        vecs.push_back(mk(1, 0, 4'd0,  1, 1, 0, 4'd0, 0));   // rst cancels pending wrap
        vecs.push_back(mk(0, 0, 4'd0,  1, 1, 0, 4'd1, 0));
        vecs.push_back(mk(0, 1, 4'd10, 0, 0, 0, 4'd9, 0));   // load_val == MODULO
        vecs.push_back(mk(0, 1, 4'd2,  0, 0, 1, 4'd2, 0));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // Held-high x_in for five cycles starting from 2.
        @(negedge clk);
        load = 1'b0; en = 1'b1; dir = 1'b0; x_in = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clk);
        x_in = 1'b0;
`ifdef MOORE_EDGE_EN
        edge_adv = 1;
`else
        edge_adv = 5;
`endif
        #1;
        chk("held_x.state", int'(state), 2 + edge_adv);
        chk("held_x.wrap", int'(wrap), 0);

        // en low with x_in toggling: nothing moves.
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            x_in = ~x_in;
            dir = i[0];
            #1;
            chk("en_low.next_state", int'(next_state), 2 + edge_adv);
            @(posedge clk);
            #1;
            chk("en_low.state", int'(state), 2 + edge_adv);
            chk("en_low.wrap", int'(wrap), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
